fxp_seq_mul: RTL and testbench

FXP_SEQ_MUL -- requirements
Module: fxp_seq_mul

---
 rtl/fxp_seq_mul.sv | 166 ++++++++++++++++
 tb/tb_fxp_seq_mul.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fxp_seq_mul.sv
// fxp_seq_mul -- sequential signed Q8.8 fixed-point multiplier.
//
// Shift-and-add on operand magnitudes: one multiplier bit per cycle, LSB
// first, for a fixed 16 cycles, then one fix-up cycle that applies the sign,
// saturates to Q8.8 and registers the result. Latency is 17 edges from the
// accepting edge to done; a new start is accepted the cycle after done.
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   start     in   1   request a multiply, sampled only when idle
//   a         in  16   signed Q8.8 multiplicand
//   b         in  16   signed Q8.8 multiplier
//   product   out 16   signed Q8.8 result, held until the next accepted start
//   busy      out  1   operation in progress
//   done      out  1   one-cycle pulse when product/overflow are valid
//   overflow  out  1   result was saturated
//
// Build option:
//   FXP_SEQ_MUL_ROUND_EN  when defined, the magnitude is rounded half up
//                         (adds accumulator bit 7); otherwise it is truncated.

module fxp_seq_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] product,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_mcand;    // |a|, shifted left once per RUN cycle
  logic [15:0] r_mplier;   // |b|, shifted right once per RUN cycle
  logic        r_sign;
  logic [31:0] r_acc;
  logic [4:0]  r_cnt;
  logic [15:0] r_product;
  logic        r_busy;
  logic        r_done;
  logic        r_ovf;

  logic        w_accept;
  logic [15:0] w_abs_a;
  logic [15:0] w_abs_b;
  logic [24:0] w_mag;      // one spare bit so rounding cannot wrap
  logic [15:0] w_res;
  logic        w_res_ovf;
  logic        w_unused_acc_lsb;

  assign w_accept = (r_state == IDLE) && start;

  // Two's-complement magnitude; 0x8000 maps to 0x8000, which is correct
  // as an unsigned 16-bit value.
  assign w_abs_a = a[15] ? (~a + 16'd1) : a;
  assign w_abs_b = b[15] ? (~b + 16'd1) : b;

`ifdef FXP_SEQ_MUL_ROUND_EN
  assign w_mag            = {1'b0, r_acc[31:8]} + {24'd0, r_acc[7]};
  assign w_unused_acc_lsb = ^r_acc[6:0];
`else
  assign w_mag            = {1'b0, r_acc[31:8]};
  assign w_unused_acc_lsb = ^r_acc[7:0];
`endif

  // Sign application and saturation. A zero magnitude always yields +0,
  // and a negative magnitude of exactly 0x8000 is representable.
  always_comb begin
    w_res     = 16'h0000;
    w_res_ovf = 1'b0;
    if (w_mag == 25'd0) begin
      w_res = 16'h0000;
    end else if (!r_sign) begin
      if (w_mag > 25'h0_7FFF) begin
        w_res     = 16'h7FFF;
        w_res_ovf = 1'b1;
      end else begin
        w_res = w_mag[15:0];
      end
    end else begin
      if (w_mag > 25'h0_8000) begin
        w_res     = 16'h8000;
        w_res_ovf = 1'b1;
      end else begin
        w_res = ~w_mag[15:0] + 16'd1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: fixed 16 RUN cycles regardless of operand values
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (r_cnt == 5'd15) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= 32'd0;
      r_mplier  <= 16'd0;
      r_sign    <= 1'b0;
      r_acc     <= 32'd0;
      r_cnt     <= 5'd0;
      r_product <= 16'h0000;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mcand  <= {16'd0, w_abs_a};
            r_mplier <= w_abs_b;
            r_sign   <= a[15] ^ b[15];
            r_acc    <= 32'd0;
            r_cnt    <= 5'd0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        RUN: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
        end
        FIX: begin
          r_product <= w_res;
          r_ovf     <= w_res_ovf;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign product  = r_product;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_fxp_seq_mul.sv
module tb_fxp_seq_mul;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a     = 16'h0;
  logic [15:0] b     = 16'h0;
  logic [15:0] product;
  logic        busy;
  logic        done;
  logic        overflow;

  fxp_seq_mul dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .product  (product),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] p;
    logic        o;
    logic [31:0] c;   // cycle count at which done must be seen
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: full signed product, magnitude scaled to Q8.8, then saturate.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic [31:0] c);
    int   p, mag, m;
    logic neg;
    exp_t e;
    p   = int'($signed(x)) * int'($signed(y));
    neg = (p < 0);
    mag = neg ? -p : p;
    m   = mag >> 8;
`ifdef FXP_SEQ_MUL_ROUND_EN
    m   = m + ((mag >> 7) & 1);
`endif
    e.c = c;
    e.o = 1'b0;
    if (m == 0) e.p = 16'h0000;
    else if (!neg) begin
      if (m > 32767) begin e.p = 16'h7FFF; e.o = 1'b1; end
      else e.p = 16'(m);
    end else begin
      if (m > 32768) begin e.p = 16'h8000; e.o = 1'b1; end
      else e.p = 16'(-m);
    end
    return e;
  endfunction

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("product", {16'd0, product}, {16'd0, e.p});
        chk("overflow", {31'd0, overflow}, {31'd0, e.o});
        chk("latency", cyc, e.c);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Drive one request; assumes the DUT will be idle at the next rising edge.
  // Operands are scrambled after acceptance to show they are not re-sampled.
  task automatic op(input logic [15:0] x, input logic [15:0] y);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    q.push_back(model(x, y, cyc + 17));
    chk("busy_on_accept", {31'd0, busy}, 32'd1);
    a = 16'($urandom); b = 16'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(negedge clk); #1;
    end
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_product", {16'd0, product}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // directed vectors, back-to-back after each done
    op(16'h0180, 16'h0200); drain();
    op(16'hFE80, 16'h0200); drain();
    op(16'h8000, 16'h0100); drain();
    op(16'h6400, 16'h0200); drain();
    op(16'h9C00, 16'h0200); drain();
    op(16'h0001, 16'h0080); drain();
    op(16'h0000, 16'h0000); drain();
    op(16'hFF00, 16'h0000); drain();
    op(16'h8000, 16'h8000); drain();
    op(16'hFFFF, 16'hFFFF); drain();

    // start pulsed again in RUN cycle 5 must be ignored
    op(16'h0180, 16'h0200);
    repeat (4) @(posedge clk);
    #1; a = 16'h7FFF; b = 16'h7FFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    drain();

    // reset in RUN cycle 8 abandons the operation
    op(16'h0300, 16'h0300);
    repeat (7) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    q.delete();
    chk("midrst_product", {16'd0, product}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (25) @(negedge clk);   // monitor flags any stray done
    #1;
    op(16'h0100, 16'h0100); drain();

    // random vectors
    for (int i = 0; i < 8; i++) begin
      op(16'($urandom), 16'($urandom));
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
